// File: rtl/clock_divider_gen.sv
// Programmable divided-clock generator: registered glitch-free clk_out with rise/fall
// strobes; divisor and enable changes only take effect at period boundaries.
module clock_divider_gen #(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             div_load,
    input  logic [WIDTH-1:0] div_value,
    output logic             clk_out,
    output logic             tick_rise,
    output logic             tick_fall,
    output logic [WIDTH-1:0] cur_div
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pvld_q, pvld_d;
    logic             clk_q, clk_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    logic             start;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] hi_m1;
    logic [WIDTH-1:0] lo_m1;

    assign load_val = (div_value < WIDTH'(2)) ? WIDTH'(2) : div_value;
    // ceil(N/2)-1 == (N-1)>>1 and floor(N/2)-1; N is always >= 2 so neither underflows
    assign hi_m1    = (active_q - WIDTH'(1)) >> 1;
    assign lo_m1    = (active_q >> 1) - WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            active_q <= WIDTH'(DEFAULT_DIV);
            pend_q   <= '0;
            pvld_q   <= 1'b0;
            clk_q    <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            pend_q   <= pend_d;
            pvld_q   <= pvld_d;
            clk_q    <= clk_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        pend_d   = pend_q;
        pvld_d   = pvld_q;
        start    = 1'b0;
        case (state_q)
            IDLE: start = en;
            HIGH: begin
                if (cnt_q == hi_m1) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end
            LOW: begin
                if (cnt_q == lo_m1) begin
                    start   = en;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // A load on the boundary edge wins over any older pending value
        if (start) begin
            state_d  = HIGH;
            cnt_d    = '0;
            active_d = div_load ? load_val : (pvld_q ? pend_q : active_q);
            pvld_d   = 1'b0;
        end else if (div_load) begin
            pend_d = load_val;
            pvld_d = 1'b1;
        end
    end

    always_comb begin
        clk_d  = (state_d == HIGH);
        rise_d = start;
        fall_d = (state_q == HIGH) && (state_d == LOW);
    end

    assign clk_out   = clk_q;
    assign tick_rise = rise_q;
    assign tick_fall = fall_q;
    assign cur_div   = active_q;

endmodule

// File: tb/tb_clock_divider_gen.sv
// Bench for clock_divider_gen: reset/table vectors, directed boundary sequences and
// randomized traffic against a period-position reference model.
module tb_clock_divider_gen;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             div_load = 1'b0;
    logic [WIDTH-1:0] div_value = '0;
    logic             clk_out, tick_rise, tick_fall;
    logic [WIDTH-1:0] cur_div;

    int checks = 0;
    int failures = 0;

    // Model: position within the running period, 0..N-1
    bit m_run;
    int m_pos, m_n, m_pd;
    bit m_pv;

    typedef struct {
        bit e;
        bit ld;
        int v;
        bit x_clk;
        bit x_rise;
        bit x_fall;
        int x_div;
    } vec_t;

    vec_t tbl[12];

    clock_divider_gen #(.WIDTH(WIDTH), .DEFAULT_DIV(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .div_load  (div_load),
        .div_value (div_value),
        .clk_out   (clk_out),
        .tick_rise (tick_rise),
        .tick_fall (tick_fall),
        .cur_div   (cur_div)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_pos = 0; m_n = 10; m_pd = 0; m_pv = 0;
    endtask

    task automatic model_edge(input bit e, input bit ld, input int v);
        int  cv;
        bit  st;
        cv = (v < 2) ? 2 : v;
        st = 0;
        if (!m_run) st = e;
        else begin
            m_pos++;
            if (m_pos == m_n) begin
                if (e) st = 1;
                else m_run = 0;
            end
        end
        if (st) begin
            m_n   = ld ? cv : (m_pv ? m_pd : m_n);
            m_pv  = 0;
            m_pos = 0;
            m_run = 1;
        end else if (ld) begin
            m_pd = cv;
            m_pv = 1;
        end
    endtask

    function automatic int hi_len();
        return (m_n + 1) / 2;
    endfunction

    task automatic step(input bit e, input bit ld, input int v);
        en = e; div_load = ld; div_value = WIDTH'(v);
        @(posedge clk);
        model_edge(e, ld, v);
        #1;
        check("clk_out", int'(clk_out), int'(m_run && m_pos < hi_len()));
        check("tick_rise", int'(tick_rise), int'(m_run && m_pos == 0));
        check("tick_fall", int'(tick_fall), int'(m_run && m_pos == hi_len()));
        check("cur_div", int'(cur_div), m_n);
    endtask

    task automatic run_to_rise();
        int n;
        n = 0;
        do begin
            step(1, 0, 0);
            n++;
        end while (!(m_run && m_pos == 0) && n < 64);
        check("rise_timeout", int'(m_run && m_pos == 0), 1);
    endtask

    initial begin
        int  n;
        bit  e, ld;
        int  v;
        model_reset();

        tbl[0]  = '{1, 0, 0, 1, 1, 0, 10};
        tbl[1]  = '{1, 0, 0, 1, 0, 0, 10};
        tbl[2]  = '{1, 0, 0, 1, 0, 0, 10};
        tbl[3]  = '{1, 0, 0, 1, 0, 0, 10};
        tbl[4]  = '{1, 0, 0, 1, 0, 0, 10};
        tbl[5]  = '{1, 0, 0, 0, 0, 1, 10};
        tbl[6]  = '{1, 0, 0, 0, 0, 0, 10};
        tbl[7]  = '{1, 0, 0, 0, 0, 0, 10};
        tbl[8]  = '{1, 0, 0, 0, 0, 0, 10};
        tbl[9]  = '{1, 0, 0, 0, 0, 0, 10};
        tbl[10] = '{1, 0, 0, 1, 1, 0, 10};
        tbl[11] = '{1, 0, 0, 1, 0, 0, 10};

        #12;
        check("rst_clk_out", int'(clk_out), 0);
        check("rst_tick_rise", int'(tick_rise), 0);
        check("rst_tick_fall", int'(tick_fall), 0);
        check("rst_cur_div", int'(cur_div), 10);
        #10 rst_n = 1'b1;

        // Default divisor 10: 5 high / 5 low
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].e, tbl[i].ld, tbl[i].v);
            check("tbl_clk_out", int'(clk_out), int'(tbl[i].x_clk));
            check("tbl_tick_rise", int'(tick_rise), int'(tbl[i].x_rise));
            check("tbl_tick_fall", int'(tick_fall), int'(tbl[i].x_fall));
            check("tbl_cur_div", int'(cur_div), tbl[i].x_div);
        end

        // Load 5 mid-HIGH: current period keeps 10
        step(1, 1, 5);
        check("midload_hold", int'(cur_div), 10);
        run_to_rise();
        check("midload_apply", int'(cur_div), 5);
        for (int i = 0; i < 6; i++) step(1, 0, 0);

        // Overwriting loads 0,1,7: only 7 applies
        step(1, 1, 0);
        step(1, 1, 1);
        step(1, 1, 7);
        run_to_rise();
        check("overwrite_apply", int'(cur_div), 7);
        for (int i = 0; i < 8; i++) step(1, 0, 0);

        // Load 1 alone clamps to 2
        step(1, 1, 1);
        run_to_rise();
        check("clamp_apply", int'(cur_div), 2);
        for (int i = 0; i < 5; i++) step(1, 0, 0);

        // N=6, drop en two cycles into HIGH
        step(1, 1, 6);
        run_to_rise();
        step(1, 0, 0);
        step(0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0);
        check("stop_clk_low", int'(clk_out), 0);
        step(1, 0, 0);
        check("restart_rise", int'(tick_rise), 1);

        // Load 6 exactly on the LOW-ending edge after running at 9
        step(1, 1, 9);
        run_to_rise();
        n = 0;
        while (!(m_run && m_pos == m_n - 1) && n < 40) begin
            step(1, 0, 0);
            n++;
        end
        check("boundary_found", int'(m_run && m_pos == m_n - 1), 1);
        step(1, 1, 6);
        check("boundary_load_div", int'(cur_div), 6);
        check("boundary_load_rise", int'(tick_rise), 1);
        for (int i = 0; i < 7; i++) step(1, 0, 0);

        // Async reset while clk_out high with a pending load
        run_to_rise();
        step(1, 1, 3);
        #2 rst_n = 1'b0;
        #1;
        check("async_clk_out", int'(clk_out), 0);
        check("async_tick_rise", int'(tick_rise), 0);
        check("async_cur_div", int'(cur_div), 10);
        model_reset();
        #3 rst_n = 1'b1;
        for (int i = 0; i < 25; i++) step(1, 0, 0);
        check("post_rst_div", int'(cur_div), 10);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            e  = ($urandom_range(0, 9) != 0);
            ld = ($urandom_range(0, 7) == 0);
            v  = int'($urandom_range(0, 13));
            step(e, ld, v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
